// File: rtl/ram_stream_reader_pkg.sv
// rtl/ram_stream_reader_pkg.sv - shared types, constants and address helper for ram_stream_reader
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int OUT_FIFO_DEPTH = 3;

  // Explicit compare so depths that are not a power of two wrap correctly.
  function automatic int unsigned next_addr(input int unsigned a, input int unsigned entries);
    return (a == entries - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - valid/ready output stream of ram_stream_reader
interface ram_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ram_stream_reader_stream_fifo3.sv
// rtl/ram_stream_reader_stream_fifo3.sv - 3-entry register FIFO with push/pop/count
module stream_fifo3
  import ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [OUT_FIFO_DEPTH];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(OUT_FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop  = pop && (count != 2'd0);
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && ((count != 2'(OUT_FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - walks a wrapping RAM address range and streams the words out
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int  WIDTH   = 8,
  parameter int  ENTRIES = 8,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] read_data,
  ram_stream_reader_if.master strm
);

  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   issue_addr;
  logic [AW:0]     remaining;
  logic [AW:0]     rem_base;
  logic            addr_vld;
  logic            data_vld;
  logic            done_q;
  logic            done_nxt;
  logic            issue;
  logic            load;
  logic            pop;
  logic            credit_ok;
  logic [2:0]      pending;
  logic [1:0]      fifo_count;
  logic            fifo_valid;
  logic [WIDTH-1:0] fifo_head;

  assign pop = fifo_valid && strm.out_ready;

  // Two reads can be in flight (address cycle, data cycle); the word leaving
  // this cycle frees its slot so 1 word/cycle is sustained with ready high.
  assign pending   = 3'(fifo_count) + 3'(addr_vld) + 3'(data_vld) - 3'(pop);
  assign credit_ok = (pending < 3'(OUT_FIFO_DEPTH));

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    load       = 1'b0;
    done_nxt   = 1'b0;
    issue_addr = addr;
    case (state)
      ST_IDLE: begin
        // The done cycle still counts as busy-ending, so a start there is dropped.
        if (start && !done_q) begin
          load = 1'b1;
          if (length == '0) begin
            state_nxt = ST_DRAIN;
          end else begin
            issue      = 1'b1;
            issue_addr = base_addr;
            state_nxt  = (length == LEN_ONE) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining == LEN_ONE) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!addr_vld && !data_vld &&
            ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rem_base = load ? length : remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      done_q    <= 1'b0;
      addr      <= '0;
      raddr     <= '0;
      remaining <= '0;
      addr_vld  <= 1'b0;
      data_vld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_q   <= done_nxt;
      addr_vld <= issue;
      data_vld <= addr_vld;
      if (issue) begin
        raddr     <= issue_addr;
        addr      <= AW'(next_addr(32'(issue_addr), ENTRIES));
        remaining <= rem_base - LEN_ONE;
      end else if (load) begin
        addr      <= base_addr;
        remaining <= length;
      end
    end
  end

  stream_fifo3 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (data_vld),
    .push_data(read_data),
    .pop      (pop),
    .head     (fifo_head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign strm.out_data  = fifo_head;
  assign strm.out_valid = fifo_valid;
  assign busy           = (state != ST_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed self-checking bench for ram_stream_reader
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] base_addr = 3'd0;
  logic [3:0] length = 4'd0;
  logic       busy;
  logic       done;
  logic [2:0] raddr;
  logic [7:0] read_data = 8'h00;
  logic [7:0] mem [8];
  int         errors = 0;
  int         checks = 0;

  ram_stream_reader_if #(.WIDTH(8)) strm ();

  ram_stream_reader #(
    .WIDTH  (8),
    .ENTRIES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .raddr    (raddr),
    .read_data(read_data),
    .strm     (strm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) read_data <= mem[raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_xfer(input string tag, input int base, input int len, input int pct,
                          input bit restart);
    logic [7:0] got[$];
    logic [2:0] prev_raddr;
    int done_cyc, first_vld, issued, accepted, max_out;
    bit seen_vld;
    logic [7:0] exp_word;
    done_cyc = -1; first_vld = -1; issued = 0; accepted = 0; max_out = 0; seen_vld = 0;
    prev_raddr = raddr;
    base_addr = 3'(base);
    length = 4'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (restart && cyc == 3) begin
        base_addr = 3'd5; length = 4'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      strm.out_ready = ($urandom_range(99) < pct);
      if (cyc == 1) begin
        check({tag, ":busy_c1"}, busy, 1);
        if (len > 0) check({tag, ":raddr_c1"}, raddr, base);
        issued = (len > 0) ? 1 : 0;
      end else if (raddr != prev_raddr) begin
        issued++;
      end
      prev_raddr = raddr;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (strm.out_valid) begin
        seen_vld = 1;
        if (first_vld < 0) first_vld = cyc;
      end
      if (strm.out_valid && strm.out_ready) begin
        got.push_back(strm.out_data);
        accepted++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    strm.out_ready = 1'b1;
    check({tag, ":done_seen"}, done_cyc >= 0, 1);
    check({tag, ":word_count"}, got.size(), len);
    for (int i = 0; i < got.size() && i < len; i++) begin
      exp_word = 8'h10 + 8'((base + i) % 8);
      check($sformatf("%s:word%0d", tag, i), got[i], exp_word);
    end
    check({tag, ":max_outstanding_le3"}, max_out <= 3, 1);
    if (len == 0) check({tag, ":no_valid"}, seen_vld, 0);
    if (pct >= 100) begin
      check({tag, ":done_cycle"}, done_cyc, (len == 0) ? 2 : len + 3);
      if (len > 0) check({tag, ":first_valid_cycle"}, first_vld, 3);
    end
    @(negedge clk);
    check({tag, ":done_one_pulse"}, done, 0);
    check({tag, ":idle_after"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    strm.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:out_valid", strm.out_valid, 0);
    check("rst:raddr", raddr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer("basic", 2, 4, 100, 0);
    run_xfer("wrap", 6, 5, 100, 0);
    run_xfer("backpressure", 0, 8, 30, 0);
    run_xfer("len0", 0, 0, 100, 0);
    run_xfer("full", 0, 8, 100, 0);
    run_xfer("restart_ignored", 1, 4, 100, 1);

    // Stall the stream so two words sit in the FIFO and one read is in flight.
    base_addr = 3'd0; length = 4'd8; strm.out_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst:valid_before", strm.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst:out_valid", strm.out_valid, 0);
    check("midrst:busy", busy, 0);
    check("midrst:raddr", raddr, 0);
    check("midrst:done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    strm.out_ready = 1'b1;
    @(negedge clk);
    run_xfer("post_rst", 3, 3, 100, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
